// File: rtl/song_reader.sv
// song_reader: walks a song's 32-entry note list in the song ROM, strobes each
// note/duration to the note player and waits for note_done between notes.
// After the last entry it pulses song_done for exactly one cycle.
// Optional build macro SONG_READER_END_MARKER_EN: a ROM entry whose duration
// is zero terminates the song early instead of being played.
module song_reader #(
  parameter int NOTES_PER_SONG_LOG2 = 5,
  parameter int NOTE_W              = 6,
  parameter int DUR_W               = 6
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             play,
  input  logic                             reset_player,
  input  logic [1:0]                       song,
  input  logic                             note_done,
  output logic [NOTES_PER_SONG_LOG2+1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]          rom_data,
  output logic [NOTE_W-1:0]                note,
  output logic [DUR_W-1:0]                 duration,
  output logic                             new_note,
  output logic                             song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_PLAY,
    S_DONE
  } state_t;

  localparam logic [NOTES_PER_SONG_LOG2-1:0] LAST_IDX = '1;

  state_t                         state;
  logic [NOTES_PER_SONG_LOG2-1:0] idx;
  logic [NOTE_W-1:0]              rom_note;
  logic [DUR_W-1:0]               rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // Song is not latched: the address always tracks the controller's selection.
  assign rom_addr = {song, idx};

  // Strobe only while actually running; a pause in EMIT holds it off.
  assign new_note = (state == S_EMIT) && play;

  // Sequencer: fetch, wait for registered ROM, emit, then wait for note_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      note      <= '0;
      duration  <= '0;
      song_done <= 1'b0;
    end else if (reset_player) begin
      state     <= S_IDLE;
      idx       <= '0;
      note      <= '0;
      duration  <= '0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (play) state <= S_FETCH;
        end
        S_FETCH: begin
          if (play) state <= S_WAIT;
        end
        S_WAIT: begin
          if (play) begin
`ifdef SONG_READER_END_MARKER_EN
            if (rom_dur == '0) begin
              state     <= S_DONE;
              song_done <= 1'b1;
            end else begin
              state    <= S_EMIT;
              note     <= rom_note;
              duration <= rom_dur;
            end
`else
            state    <= S_EMIT;
            note     <= rom_note;
            duration <= rom_dur;
`endif
          end
        end
        S_EMIT: begin
          if (play) state <= S_PLAY;
        end
        S_PLAY: begin
          if (play && note_done) begin
            if (idx == LAST_IDX) begin
              state     <= S_DONE;
              song_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          // DONE always completes regardless of play, keeping song_done one cycle.
          state <= S_IDLE;
          idx   <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader: registered song ROM model, scoreboard of expected
// {note, duration} values checked whenever new_note strobes, plus per-scenario
// timing checks. Honours SONG_READER_END_MARKER_EN when defined.
module tb_song_reader;

  logic        clk;
  logic        reset_n;
  logic        play;
  logic        reset_player;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  int total;
  int bad;
  int sd_cnt;
  logic [11:0] sb[$];

  song_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .note_done    (note_done),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_val(input logic [6:0] a);
    logic [5:0] n;
    logic [5:0] d;
    n = a[5:0] ^ 6'h2a;
    d = {1'b0, a[4:0]} + 6'd1;
`ifdef SONG_READER_END_MARKER_EN
    if (a == 7'h03) d = 6'd0;
`endif
    return {n, d};
  endfunction

  // Registered ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom_val(rom_addr);

  // Scoreboard consumer and song_done counter.
  always @(negedge clk) begin
    if (reset_n) begin
      if (song_done) sd_cnt++;
      if (new_note) begin
        logic [11:0] e;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_new_note: got note=%0h dur=%0h, required no strobe", note, duration);
        end else begin
          e = sb.pop_front();
          if ({note, duration} !== e) begin
            bad++;
            $display("FAIL note_data: got %0h/%0h, required %0h/%0h", note, duration, e[11:6], e[5:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From EMIT: move to PLAY, optionally queue the next expected note, pulse note_done.
  task automatic run_note(input bit push_next, input logic [6:0] next_addr);
    tick();
    if (push_next) sb.push_back(rom_val(next_addr));
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; play = 1'b0; reset_player = 1'b0; song = 2'd2; note_done = 1'b0;
    tick(); tick();
    total++; if (new_note !== 1'b0) begin bad++; $display("FAIL reset_new_note: got %b, required 0", new_note); end
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL reset_song_done: got %b, required 0", song_done); end
    total++; if (note !== 6'd0) begin bad++; $display("FAIL reset_note: got %0h, required 0", note); end
    total++; if (duration !== 6'd0) begin bad++; $display("FAIL reset_duration: got %0h, required 0", duration); end
    total++; if (rom_addr !== 7'h40) begin bad++; $display("FAIL reset_rom_addr: got %0h, required 40", rom_addr); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_start();
    logic [11:0] e;
    e = rom_val(7'h40);
    play = 1'b1;
    sb.push_back(e);
    tick(); tick();
    total++; if (new_note !== 1'b0) begin bad++; $display("FAIL start_early: got new_note=%b, required 0", new_note); end
    tick();
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL start_strobe: got new_note=%b, required 1", new_note); end
    total++; if ({note, duration} !== e) begin bad++; $display("FAIL start_data: got %0h/%0h, required %0h/%0h", note, duration, e[11:6], e[5:0]); end
    total++; if (rom_addr !== 7'h40) begin bad++; $display("FAIL start_addr: got %0h, required 40", rom_addr); end
  endtask

  task automatic test_pause();
    logic [6:0] a;
    for (int k = 1; k <= 5; k++) begin
      a = {2'd2, 5'(k)};
      run_note(1'b1, a);
      tick(); tick();
      total++; if (new_note !== 1'b1 || rom_addr !== a) begin bad++; $display("FAIL pause_advance: got new_note=%b addr=%0h, required 1/%0h", new_note, rom_addr, a); end
    end
    // Pause in PLAY at idx 5; note_done must be ignored.
    tick();
    play = 1'b0;
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    total++; if (rom_addr !== 7'h45) begin bad++; $display("FAIL pause_hold_addr: got %0h, required 45", rom_addr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (new_note !== 1'b0) begin bad++; $display("FAIL pause_no_strobe: got %b, required 0", new_note); end
    end
    // Resume and advance to idx 6.
    play = 1'b1;
    note_done = 1'b1;
    sb.push_back(rom_val(7'h46));
    tick();
    note_done = 1'b0;
    total++; if (rom_addr !== 7'h46) begin bad++; $display("FAIL resume_addr: got %0h, required 46", rom_addr); end
    tick(); tick();
    // Now in EMIT; pausing must suppress the strobe.
    play = 1'b0;
    #1;
    total++; if (new_note !== 1'b0) begin bad++; $display("FAIL emit_pause: got %b, required 0", new_note); end
    tick();
    total++; if (new_note !== 1'b0 || rom_addr !== 7'h46) begin bad++; $display("FAIL emit_hold: got new_note=%b addr=%0h, required 0/46", new_note, rom_addr); end
    play = 1'b1;
    #1;
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL emit_resume: got %b, required 1", new_note); end
  endtask

  task automatic test_end();
    int sd0;
    song = 2'd1;
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    total++; if (new_note !== 1'b0 || rom_addr !== 7'h20) begin bad++; $display("FAIL end_restart: got new_note=%b addr=%0h, required 0/20", new_note, rom_addr); end
    sd0 = sd_cnt;
    sb.push_back(rom_val(7'h20));
    tick(); tick(); tick();
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL end_first: got %b, required 1", new_note); end
    for (int k = 0; k < 32; k++) begin
      if (k < 31) begin
        run_note(1'b1, {2'd1, 5'(k + 1)});
        total++; if (song_done !== 1'b0) begin bad++; $display("FAIL end_early_done: got %b at idx %0d, required 0", song_done, k); end
        tick(); tick();
        total++; if (new_note !== 1'b1) begin bad++; $display("FAIL end_note_strobe: got %b at idx %0d, required 1", new_note, k + 1); end
      end else begin
        run_note(1'b0, 7'h00);
        play = 1'b0;
        total++; if (song_done !== 1'b1) begin bad++; $display("FAIL end_song_done: got %b, required 1", song_done); end
        tick();
        total++; if (song_done !== 1'b0) begin bad++; $display("FAIL end_done_width: got %b, required 0", song_done); end
        total++; if (rom_addr !== 7'h20) begin bad++; $display("FAIL end_idx_clear: got %0h, required 20", rom_addr); end
        tick(); tick();
        total++; if (new_note !== 1'b0) begin bad++; $display("FAIL end_idle: got new_note=%b, required 0", new_note); end
        total++; if (sd_cnt - sd0 !== 1) begin bad++; $display("FAIL end_done_count: got %0d, required 1", sd_cnt - sd0); end
      end
    end
  endtask

  task automatic test_restart();
    song = 2'd3;
    reset_player = 1'b1;
    play = 1'b1;
    tick();
    reset_player = 1'b0;
    sb.push_back(rom_val(7'h60));
    tick(); tick(); tick();
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL restart_first: got %b, required 1", new_note); end
    for (int k = 0; k < 10; k++) begin
      run_note(k < 9, {2'd3, 5'(k + 1)});
      if (k < 9) begin
        tick(); tick();
        total++; if (new_note !== 1'b1) begin bad++; $display("FAIL restart_walk: got %b at idx %0d, required 1", new_note, k + 1); end
      end
    end
    tick();
    total++; if (rom_addr !== 7'h6a || new_note !== 1'b0) begin bad++; $display("FAIL restart_wait: got addr=%0h new_note=%b, required 6a/0", rom_addr, new_note); end
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    play = 1'b0;
    total++; if (note !== 6'd0 || duration !== 6'd0) begin bad++; $display("FAIL restart_clear: got %0h/%0h, required 0/0", note, duration); end
    total++; if (rom_addr !== 7'h60) begin bad++; $display("FAIL restart_addr: got %0h, required 60", rom_addr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (new_note !== 1'b0) begin bad++; $display("FAIL restart_aborted: got %b, required 0", new_note); end
    end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL restart_sb: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_collision();
    int sd0;
    song = 2'd2;
    reset_player = 1'b1;
    play = 1'b1;
    tick();
    reset_player = 1'b0;
    sb.push_back(rom_val(7'h40));
    tick(); tick(); tick();
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL coll_first: got %b, required 1", new_note); end
    for (int k = 0; k < 31; k++) begin
      run_note(1'b1, {2'd2, 5'(k + 1)});
      tick(); tick();
      total++; if (new_note !== 1'b1) begin bad++; $display("FAIL coll_walk: got %b at idx %0d, required 1", new_note, k + 1); end
    end
    sd0 = sd_cnt;
    tick();
    note_done = 1'b1;
    reset_player = 1'b1;
    tick();
    note_done = 1'b0;
    reset_player = 1'b0;
    play = 1'b0;
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL coll_song_done: got %b, required 0", song_done); end
    total++; if (rom_addr !== 7'h40 || note !== 6'd0 || duration !== 6'd0) begin bad++; $display("FAIL coll_idle: got addr=%0h note=%0h dur=%0h, required 40/0/0", rom_addr, note, duration); end
    tick(); tick();
    total++; if (sd_cnt !== sd0) begin bad++; $display("FAIL coll_done_count: got %0d, required %0d", sd_cnt, sd0); end
  endtask

`ifdef SONG_READER_END_MARKER_EN
  task automatic test_marker();
    logic [11:0] e2;
    int sd0;
    e2 = rom_val(7'h02);
    song = 2'd0;
    reset_player = 1'b1;
    play = 1'b1;
    tick();
    reset_player = 1'b0;
    sd0 = sd_cnt;
    sb.push_back(rom_val(7'h00));
    tick(); tick(); tick();
    total++; if (new_note !== 1'b1) begin bad++; $display("FAIL marker_first: got %b, required 1", new_note); end
    for (int k = 0; k < 3; k++) begin
      run_note(k < 2, {2'd0, 5'(k + 1)});
      if (k < 2) begin
        tick(); tick();
        total++; if (new_note !== 1'b1) begin bad++; $display("FAIL marker_walk: got %b at idx %0d, required 1", new_note, k + 1); end
      end
    end
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL marker_early: got %b, required 0", song_done); end
    tick();
    total++; if (song_done !== 1'b0 || new_note !== 1'b0) begin bad++; $display("FAIL marker_wait: got done=%b new_note=%b, required 0/0", song_done, new_note); end
    tick();
    play = 1'b0;
    total++; if (song_done !== 1'b1 || new_note !== 1'b0) begin bad++; $display("FAIL marker_done: got done=%b new_note=%b, required 1/0", song_done, new_note); end
    total++; if ({note, duration} !== e2) begin bad++; $display("FAIL marker_noload: got %0h/%0h, required %0h/%0h", note, duration, e2[11:6], e2[5:0]); end
    tick();
    total++; if (song_done !== 1'b0 || rom_addr !== 7'h00) begin bad++; $display("FAIL marker_after: got done=%b addr=%0h, required 0/00", song_done, rom_addr); end
    tick();
    total++; if (sd_cnt - sd0 !== 1) begin bad++; $display("FAIL marker_count: got %0d, required 1", sd_cnt - sd0); end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    sd_cnt = 0;
    test_reset();
    test_start();
    test_pause();
    test_end();
    test_restart();
    test_collision();
`ifdef SONG_READER_END_MARKER_EN
    test_marker();
`endif
    tick(); tick();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL final_sb: got %0d pending, required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
